fetch_unit: RTL and testbench

Instruction-fetch stage with the fetch/decode pipeline register built in. Holds the PC, issues one instruction-bus read at a time, and presents `dataF` (valid, pc, raw_instr) to decode. Takes branch/jump redirects (`pcSrc`, `target`) from decode and the decode-stage stall from the hazard unit. A small FSM handles responses that arrive while decode is stalled, and responses that must be dropped after a redirect.

---
 rtl/common.sv | 9 +
 rtl/pipes.sv | 23 ++
 rtl/adder.sv | 12 +
 rtl/fetch_unit_pcselect.sv | 32 +++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 6 files changed

// File: rtl/common.sv
// Project-wide constants shared by the pipeline stages.
package common;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_INIT = 64'h8000_0000;

endpackage

// File: rtl/pipes.sv
// Pipeline-register payloads and per-stage state/select types.
package pipes;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_TARGET,
    SEL_PC
  } pc_sel_t;

endpackage

// File: rtl/adder.sv
// Plain parameterised two-operand adder; the carry out is discarded so sums wrap.
module adder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_unit_pcselect.sv
// Next-value selector for the fetch PC registers: hold, sequential, redirect target,
// or (request address only) catch up to the already-redirected pc.
module pcselect
  import pipes::*;
(
  input  pc_sel_t     pcSel_i,
  input  pc_sel_t     reqSel_i,
  input  logic [63:0] pcQ_i,
  input  logic [63:0] reqPcQ_i,
  input  logic [63:0] seqPc_i,
  input  logic [63:0] target_i,
  output logic [63:0] pcD_o,
  output logic [63:0] reqPcD_o
);

  function automatic logic [63:0] pick(input pc_sel_t sel, input logic [63:0] cur,
                                       input logic [63:0] seqVal, input logic [63:0] tgt,
                                       input logic [63:0] pcVal);
    logic [63:0] res;
    case (sel)
      SEL_SEQ:    res = seqVal;
      SEL_TARGET: res = tgt;
      SEL_PC:     res = pcVal;
      default:    res = cur;
    endcase
    return res;
  endfunction

  assign pcD_o    = pick(pcSel_i,  pcQ_i,    seqPc_i, target_i, pcQ_i);
  assign reqPcD_o = pick(reqSel_i, reqPcQ_i, seqPc_i, target_i, pcQ_i);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with the fetch/decode register built in; one bus read in
// flight, a skid word for responses landing under a decode stall, and stale-response drop.
module fetch_unit
  import pipes::*;
#(
  parameter logic [63:0] PC_INIT = common::PC_INIT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stallD,
  input  logic        pcSrc,
  input  logic [63:0] target,
  output fetch_data_t dataF
);

  fetch_state_t stateQ, stateD;
  logic [63:0]  pcQ, pcD;
  logic [63:0]  reqPcQ, reqPcD;
  logic [31:0]  bufInstrQ, bufInstrD;
  fetch_data_t  dataFQ, dataFD;
  pc_sel_t      pcSel, reqSel;
  logic [63:0]  seqPc;
  logic         redir;

  assign redir = dataFQ.valid & pcSrc & ~stallD;

  adder #(.WIDTH(64)) u_seqAdder (
    .a_i   (reqPcQ),
    .b_i   (64'd4),
    .sum_o (seqPc)
  );

  pcselect u_pcselect (
    .pcSel_i  (pcSel),
    .reqSel_i (reqSel),
    .pcQ_i    (pcQ),
    .reqPcQ_i (reqPcQ),
    .seqPc_i  (seqPc),
    .target_i (target),
    .pcD_o    (pcD),
    .reqPcD_o (reqPcD)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= FETCH;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      FETCH: begin
        if (iresp_data_ok) begin
          if (!redir && stallD) stateD = HOLD;
        end else if (redir) begin
          stateD = DISCARD;
        end
      end
      HOLD: begin
        if (!stallD) stateD = FETCH;
      end
      DISCARD: begin
        if (iresp_data_ok) stateD = FETCH;
      end
      default: stateD = FETCH;
    endcase
  end

  // Datapath controls; a response under stall is parked in the skid word, not dataF.
  always_comb begin
    pcSel     = SEL_HOLD;
    reqSel    = SEL_HOLD;
    dataFD    = dataFQ;
    bufInstrD = bufInstrQ;
    case (stateQ)
      FETCH: begin
        if (iresp_data_ok) begin
          if (redir) begin
            pcSel        = SEL_TARGET;
            reqSel       = SEL_TARGET;
            dataFD.valid = 1'b0;
          end else if (stallD) begin
            bufInstrD = iresp_data;
          end else begin
            dataFD = '{valid: 1'b1, pc: reqPcQ, raw_instr: iresp_data};
            pcSel  = SEL_SEQ;
            reqSel = SEL_SEQ;
          end
        end else if (redir) begin
          pcSel        = SEL_TARGET;
          dataFD.valid = 1'b0;
        end else if (!stallD) begin
          dataFD.valid = 1'b0;
        end
      end
      HOLD: begin
        if (!stallD) begin
          if (redir) begin
            pcSel        = SEL_TARGET;
            reqSel       = SEL_TARGET;
            dataFD.valid = 1'b0;
          end else begin
            dataFD = '{valid: 1'b1, pc: reqPcQ, raw_instr: bufInstrQ};
            pcSel  = SEL_SEQ;
            reqSel = SEL_SEQ;
          end
        end
      end
      DISCARD: begin
        if (iresp_data_ok) reqSel = SEL_PC;
        if (!stallD) dataFD.valid = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcQ       <= PC_INIT;
      reqPcQ    <= PC_INIT;
      bufInstrQ <= '0;
      dataFQ    <= '0;
    end else begin
      pcQ       <= pcD;
      reqPcQ    <= reqPcD;
      bufInstrQ <= bufInstrD;
      dataFQ    <= dataFD;
    end
  end

  // The request address is held through DISCARD so the bus sees a stable read.
  assign ireq_valid = ((stateQ == FETCH) || (stateQ == DISCARD)) && !reset;
  assign ireq_addr  = reqPcQ;
  assign dataF      = dataFQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall skid, redirects, reset, wrap.
module tb_fetch_unit;
  import pipes::*;

  logic        clk;
  logic        reset;
  logic        ireqValid;
  logic [63:0] ireqAddr;
  logic        irespDataOk;
  logic [31:0] irespData;
  logic        stallD;
  logic        pcSrc;
  logic [63:0] target;
  fetch_data_t dataF;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_0093;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireqValid),
    .ireq_addr     (ireqAddr),
    .iresp_data_ok (irespDataOk),
    .iresp_data    (irespData),
    .stallD        (stallD),
    .pcSrc         (pcSrc),
    .target        (target),
    .dataF         (dataF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fetch_data_t mk(input logic v, input logic [63:0] p, input logic [31:0] w);
    fetch_data_t d;
    d.valid     = v;
    d.pc        = p;
    d.raw_instr = w;
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's inputs at the falling edge; returns just after the rising edge.
  task automatic applyStimulus(input logic r, input logic ok, input logic [31:0] data,
                               input logic st, input logic ps, input logic [63:0] tgt);
    @(negedge clk);
    reset       = r;
    irespDataOk = ok;
    irespData   = data;
    stallD      = st;
    pcSrc       = ps;
    target      = tgt;
    if (ps) checkOutput("target_aligned", 128'(tgt[1:0]), 128'(2'b00));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; irespDataOk = 1'b0; irespData = '0;
    stallD = 1'b0; pcSrc = 1'b0; target = '0;

    $display("[TB] reset state");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_dataF", 128'(dataF), 128'(0));
    checkOutput("rst_ireq_valid", 128'(ireqValid), 128'(0));
    checkOutput("rst_ireq_addr", 128'(ireqAddr), 128'(64'h8000_0000));

    $display("[TB] sequential zero-wait fetch");
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("seq0", 128'(dataF), 128'(mk(1, 64'h8000_0000, NOP)));
    checkOutput("seq0_req", 128'({ireqValid, ireqAddr}), 128'({1'b1, 64'h8000_0004}));
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("seq1", 128'(dataF), 128'(mk(1, 64'h8000_0004, NOP)));
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("seq2", 128'(dataF), 128'(mk(1, 64'h8000_0008, NOP)));

    $display("[TB] stall during response");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("stl_pre", 128'(dataF), 128'(mk(1, 64'h8000_0000, NOP)));
    applyStimulus(0, 1, ADDI, 1, 0, 0);
    checkOutput("stl_state", 128'(dut.stateQ), 128'(HOLD));
    checkOutput("stl_ireq_valid", 128'(ireqValid), 128'(0));
    checkOutput("stl_frozen1", 128'(dataF), 128'(mk(1, 64'h8000_0000, NOP)));
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("stl_frozen3", 128'(dataF), 128'(mk(1, 64'h8000_0000, NOP)));
    checkOutput("stl_hold_valid", 128'(ireqValid), 128'(0));
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stl_release", 128'(dataF), 128'(mk(1, 64'h8000_0004, ADDI)));
    checkOutput("stl_next_req", 128'({ireqValid, ireqAddr}), 128'({1'b1, 64'h8000_0008}));
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stl_once", 128'(dataF.valid), 128'(0));

    $display("[TB] redirect with zero-wait bus");
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("rz_pre", 128'(dataF), 128'(mk(1, 64'h8000_0008, NOP)));
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 1, 64'h8000_0100);
    checkOutput("rz_bubble", 128'(dataF.valid), 128'(0));
    checkOutput("rz_req", 128'(ireqAddr), 128'(64'h8000_0100));
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("rz_target", 128'(dataF), 128'(mk(1, 64'h8000_0100, NOP)));

    $display("[TB] redirect while waiting");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, NOP, 0, 0, 0);
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("rw_pre", 128'(dataF), 128'(mk(1, 64'h8000_0004, NOP)));
    applyStimulus(0, 0, 0, 0, 1, 64'h8000_0200);
    checkOutput("rw_bubble", 128'(dataF.valid), 128'(0));
    checkOutput("rw_addr1", 128'({ireqValid, ireqAddr}), 128'({1'b1, 64'h8000_0008}));
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rw_addr2", 128'({ireqValid, ireqAddr}), 128'({1'b1, 64'h8000_0008}));
    applyStimulus(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    checkOutput("rw_stale_dropped", 128'(dataF.valid), 128'(0));
    checkOutput("rw_new_addr", 128'({ireqValid, ireqAddr}), 128'({1'b1, 64'h8000_0200}));
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("rw_target", 128'(dataF), 128'(mk(1, 64'h8000_0200, NOP)));

    $display("[TB] redirect on stall release");
    applyStimulus(0, 1, 32'h0020_0113, 1, 0, 0);
    checkOutput("rs_hold", 128'(ireqValid), 128'(0));
    applyStimulus(0, 0, 0, 0, 1, 64'h8000_0300);
    checkOutput("rs_bubble", 128'(dataF.valid), 128'(0));
    checkOutput("rs_req", 128'({ireqValid, ireqAddr}), 128'({1'b1, 64'h8000_0300}));
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("rs_target", 128'(dataF), 128'(mk(1, 64'h8000_0300, NOP)));

    $display("[TB] reset mid-request");
    checkOutput("rm_pre_valid", 128'(ireqValid), 128'(1));
    applyStimulus(1, 1, 32'hFFFF_FFFF, 0, 0, 0);
    checkOutput("rm_ireq_valid", 128'(ireqValid), 128'(0));
    checkOutput("rm_dataF_valid", 128'(dataF.valid), 128'(0));
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("rm_restart", 128'(dataF), 128'(mk(1, 64'h8000_0000, NOP)));

    $display("[TB] pc wrap");
    applyStimulus(0, 1, NOP, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wr_bubble", 128'(dataF.valid), 128'(0));
    applyStimulus(0, 1, NOP, 0, 0, 0);
    checkOutput("wr_top", 128'(dataF), 128'(mk(1, 64'hFFFF_FFFF_FFFF_FFFC, NOP)));
    applyStimulus(0, 1, ADDI, 0, 0, 0);
    checkOutput("wr_zero", 128'(dataF), 128'(mk(1, 64'h0, ADDI)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
